// File: rtl/uart_debug_ctrl_pkg.sv
// Shared definitions for the UART debug controller: command/response codes,
// FSM state encoding and word/byte geometry helpers.
package uart_debug_ctrl_pkg;

  localparam int unsigned NB_BYTE     = 8;
  localparam int unsigned NB_DATA_DEF = 32;
  localparam int unsigned BYTES_PER_WORD = NB_DATA_DEF / NB_BYTE;

  // Load word count holds 1..256 (a count byte of 0 means 256)
  localparam int unsigned NB_WCNT = 9;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_DUMP = 8'h44;
  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_NAK  = 8'h15;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_LOAD_CNT  = 4'd1,
    ST_LOAD_BYTE = 4'd2,
    ST_LOAD_WR   = 4'd3,
    ST_RUN       = 4'd4,
    ST_STEP      = 4'd5,
    ST_DUMP_ADDR = 4'd6,
    ST_DUMP_LAT  = 4'd7,
    ST_DUMP_TX   = 4'd8,
    ST_SEND      = 4'd9
  } state_t;

  function automatic int unsigned bytes_per_word(input int unsigned nb_data);
    return nb_data / NB_BYTE;
  endfunction

endpackage

// File: rtl/uart_debug_ctrl_word_shifter.sv
// Assembles / serialises an NB_DATA word one byte at a time, LSB byte first.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   clr             clear word and byte count
//   load            load load_data as the word, byte count to 0
//   load_data       parallel word to serialise
//   shift_in        insert in_byte at the top, shift word down one byte
//   in_byte         byte to insert
//   shift_out       shift word down one byte (low byte is the one leaving)
//   word            current word register
//   cnt             bytes shifted since last clr/load
//   done            cnt has reached the number of bytes per word
module uart_debug_ctrl_word_shifter
  import uart_debug_ctrl_pkg::*;
#(
  parameter int unsigned NB_DATA = 32,
  localparam int unsigned BPW    = bytes_per_word(NB_DATA),
  localparam int unsigned NCW    = $clog2(BPW + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               load,
  input  logic [NB_DATA-1:0] load_data,
  input  logic               shift_in,
  input  logic [7:0]         in_byte,
  input  logic               shift_out,
  output logic [NB_DATA-1:0] word,
  output logic [NCW-1:0]     cnt,
  output logic               done
);

  // Bytes enter at the top so the first byte ends up in the low lane
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else if (clr) begin
      word <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else if (load) begin
      word <= load_data;
      cnt  <= '0;
      done <= 1'b0;
    end else if (shift_in || shift_out) begin
      word <= (word >> NB_BYTE) |
              (NB_DATA'(shift_in ? in_byte : 8'h00) << (NB_DATA - NB_BYTE));
      cnt  <= cnt + NCW'(1);
      done <= (cnt == NCW'(BPW - 1));
    end
  end

endmodule

// File: rtl/uart_debug_ctrl.sv
// Command sequencer between the UART byte FIFOs and the pipeline debug port.
// Decodes L(oad) / R(un) / S(tep) / D(ump) commands from the RX FIFO, writes
// program words, controls run/step, streams registers back through TX.
// Ports:
//   i_clk, i_reset                 clock, async active-low reset
//   i_rx_empty, i_r_data, o_rd_uart  RX FIFO head and pop
//   i_tx_full, o_wr_uart, o_w_data   TX FIFO status and push
//   o_prog_we/addr/data            instruction memory write port
//   o_run, o_step, i_halt          pipeline run control
//   o_dbg_addr, i_dbg_data         register file debug read port
module uart_debug_ctrl
  import uart_debug_ctrl_pkg::*;
#(
  parameter int unsigned NB_DATA  = 32,
  parameter int unsigned NB_PADDR = 8,
  parameter int unsigned NB_RADDR = 5,
  parameter int unsigned NREG     = 32
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_rx_empty,
  input  logic [7:0]          i_r_data,
  output logic                o_rd_uart,
  input  logic                i_tx_full,
  output logic                o_wr_uart,
  output logic [7:0]          o_w_data,
  output logic                o_prog_we,
  output logic [NB_PADDR-1:0] o_prog_addr,
  output logic [NB_DATA-1:0]  o_prog_data,
  output logic                o_run,
  output logic                o_step,
  input  logic                i_halt,
  output logic [NB_RADDR-1:0] o_dbg_addr,
  input  logic [NB_DATA-1:0]  i_dbg_data
);

  localparam int unsigned BPW    = bytes_per_word(NB_DATA);
  localparam int unsigned NCW    = $clog2(BPW + 1);
  localparam int unsigned NB_IDX = NB_RADDR + 1;

  state_t               state, state_nx;
  logic                 rd_nx, wr_nx, prog_we_nx, run_nx, step_nx;
  logic [7:0]           w_data_nx;
  logic [NB_PADDR-1:0]  prog_addr_nx;
  logic [NB_RADDR-1:0]  dbg_addr_nx;
  logic [NB_WCNT-1:0]   rem, rem_nx;
  logic [NB_IDX-1:0]    idx, idx_nx, idx_inc;
  logic [7:0]           rsp, rsp_nx;

  logic                 rx_clr, rx_shift, tx_load, tx_shift;
  logic [NCW-1:0]       rx_cnt, tx_cnt;
  logic                 rx_done, tx_done;
  logic [NB_DATA-1:0]   tx_word;
  logic                 unused_sink;

  // Receive-side word assembly feeds the program data port directly
  uart_debug_ctrl_word_shifter #(.NB_DATA(NB_DATA)) u_rx_shifter (
    .clk       (i_clk),
    .rst_n     (i_reset),
    .clr       (rx_clr),
    .load      (1'b0),
    .load_data ('0),
    .shift_in  (rx_shift),
    .in_byte   (i_r_data),
    .shift_out (1'b0),
    .word      (o_prog_data),
    .cnt       (rx_cnt),
    .done      (rx_done)
  );

  // Transmit-side serialiser for register dump words
  uart_debug_ctrl_word_shifter #(.NB_DATA(NB_DATA)) u_tx_shifter (
    .clk       (i_clk),
    .rst_n     (i_reset),
    .clr       (1'b0),
    .load      (tx_load),
    .load_data (i_dbg_data),
    .shift_in  (1'b0),
    .in_byte   (8'h00),
    .shift_out (tx_shift),
    .word      (tx_word),
    .cnt       (tx_cnt),
    .done      (tx_done)
  );

  assign unused_sink = ^{rx_done, tx_word, tx_cnt};
  assign idx_inc     = idx + NB_IDX'(1);

  // State and registered outputs
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state       <= ST_IDLE;
      o_rd_uart   <= 1'b0;
      o_wr_uart   <= 1'b0;
      o_w_data    <= '0;
      o_prog_we   <= 1'b0;
      o_prog_addr <= '0;
      o_run       <= 1'b0;
      o_step      <= 1'b0;
      o_dbg_addr  <= '0;
      rem         <= '0;
      idx         <= '0;
      rsp         <= '0;
    end else begin
      state       <= state_nx;
      o_rd_uart   <= rd_nx;
      o_wr_uart   <= wr_nx;
      o_w_data    <= w_data_nx;
      o_prog_we   <= prog_we_nx;
      o_prog_addr <= prog_addr_nx;
      o_run       <= run_nx;
      o_step      <= step_nx;
      o_dbg_addr  <= dbg_addr_nx;
      rem         <= rem_nx;
      idx         <= idx_nx;
      rsp         <= rsp_nx;
    end
  end

  // A pop is requested one cycle, then the byte is taken in the cycle
  // o_rd_uart is high; a push likewise leaves a gap so the FIFO flags
  // catch up before the next request.
  always_comb begin
    state_nx     = state;
    rd_nx        = 1'b0;
    wr_nx        = 1'b0;
    w_data_nx    = o_w_data;
    prog_we_nx   = 1'b0;
    prog_addr_nx = o_prog_addr;
    run_nx       = 1'b0;
    step_nx      = 1'b0;
    dbg_addr_nx  = o_dbg_addr;
    rem_nx       = rem;
    idx_nx       = idx;
    rsp_nx       = rsp;
    rx_clr       = 1'b0;
    rx_shift     = 1'b0;
    tx_load      = 1'b0;
    tx_shift     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (o_rd_uart) begin
          case (i_r_data)
            CMD_LOAD: state_nx = ST_LOAD_CNT;
            CMD_RUN: begin
              state_nx = ST_RUN;
              run_nx   = 1'b1;
            end
            CMD_STEP: begin
              state_nx = ST_STEP;
              step_nx  = 1'b1;
            end
            CMD_DUMP: begin
              state_nx    = ST_DUMP_ADDR;
              idx_nx      = '0;
              dbg_addr_nx = '0;
            end
            default: begin
              state_nx = ST_SEND;
              rsp_nx   = RSP_NAK;
            end
          endcase
        end else if (!i_rx_empty) begin
          rd_nx = 1'b1;
        end
      end

      ST_LOAD_CNT: begin
        if (o_rd_uart) begin
          rem_nx       = (i_r_data == 8'h00) ? NB_WCNT'(256) : NB_WCNT'(i_r_data);
          prog_addr_nx = '0;
          rx_clr       = 1'b1;
          state_nx     = ST_LOAD_BYTE;
        end else if (!i_rx_empty) begin
          rd_nx = 1'b1;
        end
      end

      ST_LOAD_BYTE: begin
        if (o_rd_uart) begin
          rx_shift = 1'b1;
          if (rx_cnt == NCW'(BPW - 1)) begin
            prog_we_nx = 1'b1;
            state_nx   = ST_LOAD_WR;
          end
        end else if (!i_rx_empty) begin
          rd_nx = 1'b1;
        end
      end

      // Write pulse is high this cycle; advance address and count
      ST_LOAD_WR: begin
        prog_addr_nx = o_prog_addr + NB_PADDR'(1);
        rem_nx       = rem - NB_WCNT'(1);
        rx_clr       = 1'b1;
        if (rem != NB_WCNT'(1)) begin
          state_nx = ST_LOAD_BYTE;
        end else begin
          state_nx = ST_SEND;
          rsp_nx   = RSP_ACK;
        end
      end

      ST_RUN: begin
        if (i_halt) begin
          state_nx = ST_SEND;
          rsp_nx   = RSP_ACK;
        end else begin
          run_nx = 1'b1;
        end
      end

      ST_STEP: begin
        state_nx = ST_SEND;
        rsp_nx   = RSP_ACK;
      end

      ST_DUMP_ADDR: state_nx = ST_DUMP_LAT;

      ST_DUMP_LAT: begin
        tx_load  = 1'b1;
        state_nx = ST_DUMP_TX;
      end

      ST_DUMP_TX: begin
        if (!o_wr_uart) begin
          if (tx_done) begin
            idx_nx = idx_inc;
            if (32'(idx_inc) < NREG) begin
              state_nx    = ST_DUMP_ADDR;
              dbg_addr_nx = idx_inc[NB_RADDR-1:0];
            end else begin
              state_nx = ST_SEND;
              rsp_nx   = RSP_ACK;
            end
          end else if (!i_tx_full) begin
            wr_nx     = 1'b1;
            w_data_nx = tx_word[7:0];
            tx_shift  = 1'b1;
          end
        end
      end

      ST_SEND: begin
        if (!o_wr_uart && !i_tx_full) begin
          wr_nx     = 1'b1;
          w_data_nx = rsp;
          state_nx  = ST_IDLE;
        end
      end

      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_debug_ctrl.sv
// Self-checking bench for uart_debug_ctrl: RX/TX FIFO models, instruction
// memory and register file models, and an expected-response queue.
module tb_uart_debug_ctrl;

  localparam int unsigned NB_DATA  = 32;
  localparam int unsigned NB_PADDR = 8;
  localparam int unsigned NB_RADDR = 5;
  localparam int unsigned NREG     = 32;
  localparam int TMO = 30000;

  logic                i_clk = 1'b0;
  logic                i_reset;
  logic                i_rx_empty;
  logic [7:0]          i_r_data;
  logic                o_rd_uart;
  logic                i_tx_full;
  logic                o_wr_uart;
  logic [7:0]          o_w_data;
  logic                o_prog_we;
  logic [NB_PADDR-1:0] o_prog_addr;
  logic [NB_DATA-1:0]  o_prog_data;
  logic                o_run;
  logic                o_step;
  logic                i_halt;
  logic [NB_RADDR-1:0] o_dbg_addr;
  logic [NB_DATA-1:0]  i_dbg_data;

  uart_debug_ctrl #(
    .NB_DATA(NB_DATA), .NB_PADDR(NB_PADDR), .NB_RADDR(NB_RADDR), .NREG(NREG)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_rx_empty(i_rx_empty), .i_r_data(i_r_data), .o_rd_uart(o_rd_uart),
    .i_tx_full(i_tx_full), .o_wr_uart(o_wr_uart), .o_w_data(o_w_data),
    .o_prog_we(o_prog_we), .o_prog_addr(o_prog_addr), .o_prog_data(o_prog_data),
    .o_run(o_run), .o_step(o_step), .i_halt(i_halt),
    .o_dbg_addr(o_dbg_addr), .i_dbg_data(i_dbg_data)
  );

  always #5 i_clk = ~i_clk;

  // RX FIFO model: bench pushes, DUT pops
  logic [7:0] rx_mem [0:4095];
  int rx_wp = 0;
  int rx_rp = 0;
  assign i_rx_empty = (rx_wp == rx_rp);
  assign i_r_data   = rx_mem[rx_rp];

  logic [7:0]  tx_q [$];
  logic [7:0]  exp_tx [$];
  int          tx_chk = 0;
  logic [31:0] imem    [0:255];
  logic [31:0] exp_mem [0:255];
  logic [31:0] regs    [0:NREG-1];

  int cyc = 0, we_cnt = 0, step_cnt = 0, run_cnt = 0;
  int last_pop = 0, last_we = 0, last_step = 0, bad_pop = 0, bad_push = 0;
  int nchk = 0, nerr = 0;

  // Environment: FIFO sides, memory write port, register read port, monitors
  always @(posedge i_clk) begin
    cyc <= cyc + 1;
    if (o_rd_uart) begin
      if (rx_rp == rx_wp) bad_pop <= bad_pop + 1;
      else rx_rp <= rx_rp + 1;
      last_pop <= cyc;
    end
    if (o_wr_uart) begin
      if (i_tx_full) bad_push <= bad_push + 1;
      tx_q.push_back(o_w_data);
    end
    if (o_prog_we) begin
      imem[o_prog_addr] <= o_prog_data;
      we_cnt  <= we_cnt + 1;
      last_we <= cyc;
    end
    if (o_step) begin
      step_cnt  <= step_cnt + 1;
      last_step <= cyc;
    end
    if (o_run) run_cnt <= run_cnt + 1;
    i_dbg_data <= regs[o_dbg_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_rx(input logic [7:0] b);
    rx_mem[rx_wp] = b;
    rx_wp++;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) push_rx(w[8*b +: 8]);
  endtask

  // Wait for every expected TX byte, then compare them in order
  task automatic check_tx(input string tag);
    int t = 0;
    while (tx_q.size() < exp_tx.size() && t < TMO) begin
      @(negedge i_clk);
      t++;
    end
    chk({tag, "_tmo"}, 32'(tx_q.size() >= exp_tx.size()), 32'd1);
    repeat (8) @(negedge i_clk);
    chk({tag, "_cnt"}, 32'(tx_q.size()), 32'(exp_tx.size()));
    for (int i = tx_chk; i < exp_tx.size(); i++)
      chk(tag, (i < tx_q.size()) ? 32'(tx_q[i]) : 32'hFFFF_FFFF, 32'(exp_tx[i]));
    tx_chk = exp_tx.size();
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_rd"},   32'(o_rd_uart),   32'd0);
    chk({tag, "_wr"},   32'(o_wr_uart),   32'd0);
    chk({tag, "_wd"},   32'(o_w_data),    32'd0);
    chk({tag, "_we"},   32'(o_prog_we),   32'd0);
    chk({tag, "_pa"},   32'(o_prog_addr), 32'd0);
    chk({tag, "_pd"},   32'(o_prog_data), 32'd0);
    chk({tag, "_run"},  32'(o_run),       32'd0);
    chk({tag, "_step"}, 32'(o_step),      32'd0);
    chk({tag, "_da"},   32'(o_dbg_addr),  32'd0);
  endtask

  task automatic do_dump(input string tag, input bit stall);
    int t;
    int hold_sz;
    logic [7:0] hold_wd;
    push_rx(8'h44);
    for (int k = 0; k < NREG; k++)
      for (int b = 0; b < 4; b++) exp_tx.push_back(regs[k][8*b +: 8]);
    exp_tx.push_back(8'h06);
    if (stall) begin
      t = 0;
      while (!(tx_q.size() >= tx_chk + 40 && !o_wr_uart) && t < TMO) begin
        @(negedge i_clk);
        t++;
      end
      chk({tag, "_reach"}, 32'(tx_q.size() >= tx_chk + 40), 32'd1);
      i_tx_full = 1'b1;
      hold_sz = tx_q.size();
      hold_wd = o_w_data;
      repeat (20) @(negedge i_clk);
      chk({tag, "_hold_cnt"}, 32'(tx_q.size()), 32'(hold_sz));
      chk({tag, "_hold_wd"},  32'(o_w_data),   32'(hold_wd));
      i_tx_full = 1'b0;
    end
    check_tx(tag);
  endtask

  initial begin
    int base_we, base_step, base_run, rp_hold, n, t;
    logic [7:0] bad;
    logic [31:0] w;

    i_reset = 1'b1; i_tx_full = 1'b0; i_halt = 1'b0;
    for (int k = 0; k < NREG; k++) regs[k] = 32'(k) * 32'h0101_0101;
    #1 i_reset = 1'b0;
    repeat (3) @(negedge i_clk);
    check_idle_outputs("reset");
    i_reset = 1'b1;
    repeat (2) @(negedge i_clk);

    // Load two words
    base_we = we_cnt;
    push_rx(8'h4C); push_rx(8'h02);
    push_word(32'h1234_5678); push_word(32'hDEAD_BEEF);
    exp_tx.push_back(8'h06);
    check_tx("load2");
    chk("load2_mem0", imem[0], 32'h1234_5678);
    chk("load2_mem1", imem[1], 32'hDEAD_BEEF);
    chk("load2_we_pulses", 32'(we_cnt - base_we), 32'd2);
    chk("load2_we_latency", 32'(last_we - last_pop), 32'd1);
    chk("load2_addr", 32'(o_prog_addr), 32'd2);

    // Single step, then single step with halt high (ignored)
    for (int h = 0; h < 2; h++) begin
      i_halt = h[0];
      base_step = step_cnt; base_run = run_cnt;
      push_rx(8'h53);
      exp_tx.push_back(8'h06);
      check_tx("step");
      chk("step_pulses", 32'(step_cnt - base_step), 32'd1);
      chk("step_latency", 32'(last_step - last_pop), 32'd1);
      chk("step_no_run", 32'(run_cnt - base_run), 32'd0);
    end
    i_halt = 1'b0;

    // Run, halt 50 cycles after o_run rises; a byte sent meanwhile stays queued
    base_run = run_cnt;
    push_rx(8'h52);
    t = 0;
    while (!o_run && t < 200) begin @(negedge i_clk); t++; end
    chk("run_rise", 32'(o_run), 32'd1);
    repeat (10) @(negedge i_clk);
    rp_hold = rx_rp;
    push_rx(8'h7A);
    repeat (40) @(negedge i_clk);
    chk("run_no_pop", 32'(rx_rp), 32'(rp_hold));
    chk("run_still_high", 32'(o_run), 32'd1);
    i_halt = 1'b1;
    exp_tx.push_back(8'h06);
    exp_tx.push_back(8'h15);
    check_tx("run");
    chk("run_cycles", 32'(run_cnt - base_run), 32'd51);

    // Run with halt already high: one cycle of o_run
    base_run = run_cnt;
    push_rx(8'h52);
    exp_tx.push_back(8'h06);
    check_tx("run_halted");
    chk("run_halted_cycles", 32'(run_cnt - base_run), 32'd1);
    i_halt = 1'b0;

    // Dump with a TX stall mid-stream
    do_dump("dump_stall", 1'b1);
    chk("no_push_while_full", 32'(bad_push), 32'd0);

    // Unknown byte -> NAK, then FSM must accept the next command
    push_rx(8'h7A);
    exp_tx.push_back(8'h15);
    check_tx("nak");

    // Random loads and random unknown bytes
    for (int it = 0; it < 4; it++) begin
      n = $urandom_range(1, 6);
      push_rx(8'h4C); push_rx(8'(n));
      for (int a = 0; a < n; a++) begin
        w = $urandom;
        exp_mem[a] = w;
        push_word(w);
      end
      exp_tx.push_back(8'h06);
      do bad = 8'($urandom_range(0, 255));
      while (bad == 8'h4C || bad == 8'h52 || bad == 8'h53 || bad == 8'h44);
      push_rx(bad);
      exp_tx.push_back(8'h15);
      check_tx("rnd_load");
      for (int a = 0; a < n; a++) chk("rnd_mem", imem[a], exp_mem[a]);
    end

    // Random register contents dump
    for (int k = 0; k < NREG; k++) regs[k] = $urandom;
    do_dump("dump_rnd", 1'b0);

    // Count byte 0 loads 256 words; address wraps back to 0
    base_we = we_cnt;
    push_rx(8'h4C); push_rx(8'h00);
    for (int a = 0; a < 256; a++) begin
      w = $urandom;
      exp_mem[a] = w;
      push_word(w);
    end
    exp_tx.push_back(8'h06);
    check_tx("load256");
    chk("load256_we_pulses", 32'(we_cnt - base_we), 32'd256);
    chk("load256_addr_wrap", 32'(o_prog_addr), 32'd0);
    for (int a = 0; a < 256; a++) chk("load256_mem", imem[a], exp_mem[a]);

    // Reset in the middle of a load payload aborts it silently
    base_we = we_cnt;
    push_rx(8'h4C); push_rx(8'h03);
    push_rx(8'hAA); push_rx(8'hBB); push_rx(8'hCC);
    t = 0;
    while (rx_rp != rx_wp && t < 500) begin @(negedge i_clk); t++; end
    chk("abort_drained", 32'(rx_rp == rx_wp), 32'd1);
    repeat (3) @(negedge i_clk);
    i_reset = 1'b0;
    repeat (2) @(negedge i_clk);
    check_idle_outputs("abort");
    chk("abort_no_we", 32'(we_cnt - base_we), 32'd0);
    i_reset = 1'b1;
    repeat (2) @(negedge i_clk);
    base_step = step_cnt;
    push_rx(8'h53);
    exp_tx.push_back(8'h06);
    check_tx("post_reset_step");
    chk("post_reset_step_pulses", 32'(step_cnt - base_step), 32'd1);

    chk("no_pop_when_empty", 32'(bad_pop), 32'd0);
    chk("no_push_when_full", 32'(bad_push), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
